mem_rw_port: RTL and testbench

- Parametrised single-port data memory with a valid/ready request channel and a buffered response channel, replacing the fixed 1024x32 level-triggered memory.
- Adds clocked access, per-byte write strobes, out-of-range error signalling and back-pressure.
- Sits between the processor load/store stage and the data store.
- Every accepted request (read or write) returns exactly one response, in order.

---
 rtl/mem_rw_port.sv | 105 ++++++++++
 tb/tb_mem_rw_port.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rw_port.sv
// Single-port data memory behind a valid/ready request channel, with a one-entry
// response buffer, per-byte write strobes and out-of-range error responses.
module mem_rw_port #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_is_write,
    output logic                  resp_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_reg;
    state_t                state_next;
    logic                  accept;
    logic                  drain;
    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  resp_is_write_reg;
    logic                  resp_err_reg;
    logic                  rd_sel_reg;

    assign resp_valid = (state_reg == FULL);
    // Ready is held low while in reset so nothing reaches the un-reset array.
    assign req_ready  = rst_n && (!resp_valid || resp_ready);
    assign accept     = req_valid && req_ready;
    assign drain      = resp_valid && resp_ready;
    assign in_range   = {1'b0, req_addr} < DEPTH_LIM;
    assign wr_en      = accept && req_rw && in_range;
    assign rd_en      = accept && !req_rw && in_range;
    assign mem_idx    = req_addr[IDX_W-1:0];

    // One byte-wide array per lane so each strobe maps onto a RAM byte enable.
    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (wr_en && req_strb[gi]) begin
                    lane_mem[mem_idx] <= req_wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    rd_byte_reg <= lane_mem[mem_idx];
                end
            end

            assign rd_data[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= EMPTY;
            resp_is_write_reg <= 1'b0;
            resp_err_reg      <= 1'b0;
            rd_sel_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                resp_is_write_reg <= req_rw;
                resp_err_reg      <= !in_range;
                rd_sel_reg        <= !req_rw && in_range;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (drain && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // The RAM output register has no reset; the select flag forces zero for
    // writes, errors and after reset, and holds the last read while draining.
    assign resp_rdata    = rd_sel_reg ? rd_data : '0;
    assign resp_is_write = resp_is_write_reg;
    assign resp_err      = resp_err_reg;

endmodule

// File: tb/tb_mem_rw_port.sv
// Randomised and directed bench for mem_rw_port with a queue-based response model.
module tb_mem_rw_port;

    localparam int DW    = 32;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam int SW    = DW / 8;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          wr;
        logic          err;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_is_write;
    logic          resp_err;

    int n_checks = 0;
    int n_fails  = 0;
    int n_accepted = 0;
    int n_drained  = 0;
    int n_discarded = 0;
    int n_sent = 0;
    int cyc = 0;
    int rr_mode = 0;
    logic rr_force = 1'b1;

    logic [DW-1:0] model_mem [DEPTH];
    resp_t         exp_q [$];
    logic [DW-1:0] last_rdata;
    logic          last_wr;
    logic          last_err;

    mem_rw_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_strb     (req_strb),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_is_write(resp_is_write),
        .resp_err     (resp_err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: always ready, randomly stalling, or forced to rr_force.
    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 3) != 0);
            default: resp_ready = rr_force;
        endcase
    end

    // Reference model: the response buffer is a queue of at most one entry.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            n_discarded += exp_q.size();
            exp_q.delete();
        end else begin
            bit    m_ready;
            resp_t r;
            m_ready = (exp_q.size() == 0) || resp_ready;
            check("req_ready", DW'(req_ready), DW'(m_ready));
            check("resp_valid", DW'(resp_valid), DW'(exp_q.size() != 0));
            if (exp_q.size() != 0 && resp_valid) begin
                check("resp_rdata", resp_rdata, exp_q[0].rdata);
                check("resp_is_write", DW'(resp_is_write), DW'(exp_q[0].wr));
                check("resp_err", DW'(resp_err), DW'(exp_q[0].err));
            end
            if (exp_q.size() != 0 && resp_ready) begin
                last_rdata = resp_rdata;
                last_wr    = resp_is_write;
                last_err   = resp_err;
                void'(exp_q.pop_front());
                n_drained++;
            end
            if (req_valid && m_ready) begin
                if (int'(req_addr) >= DEPTH) begin
                    r = '{rdata: '0, wr: req_rw, err: 1'b1};
                end else if (req_rw) begin
                    for (int b = 0; b < SW; b++) begin
                        if (req_strb[b]) model_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                    r = '{rdata: '0, wr: 1'b1, err: 1'b0};
                end else begin
                    r = '{rdata: model_mem[req_addr], wr: 1'b0, err: 1'b0};
                end
                exp_q.push_back(r);
                n_accepted++;
            end
        end
    end

    task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int guard = 0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        n_sent++;
        @(negedge clk);
        while (!req_ready && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: got no acceptance, expected one within 1000 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int guard = 0;
        @(negedge clk);
        #1;
        while ((n_drained + n_discarded) != n_accepted && guard < 1000) begin
            guard++;
            @(negedge clk);
            #1;
        end
        if ((n_drained + n_discarded) != n_accepted) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", n_accepted - n_drained - n_discarded);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        send(rw, a, d, s);
        req_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w15;
        int c0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_rw = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_strb = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_valid", DW'(resp_valid), 0);
        rst_n = 1'b1;
        #1;
        check("idle_resp_valid", DW'(resp_valid), 0);
        check("idle_req_ready", DW'(req_ready), 1);
        check("idle_resp_rdata", resp_rdata, 0);

        // Give every word a known value.
        for (int a = 0; a < DEPTH; a++) send(1'b1, AW'(a), $urandom, '1);
        req_valid = 1'b0;
        wait_drain();

        txn(1'b1, 10'd5, 32'hDEADBEEF, 4'b1111);
        check("full_wr_is_write", DW'(last_wr), 1);
        check("full_wr_err", DW'(last_err), 0);
        check("full_wr_rdata", last_rdata, 0);
        txn(1'b0, 10'd5, 32'h0, 4'b0000);
        check("full_rd_rdata", last_rdata, 32'hDEADBEEF);
        check("full_rd_is_write", DW'(last_wr), 0);
        txn(1'b1, 10'd5, 32'h11223344, 4'b0101);
        txn(1'b0, 10'd5, 32'h0, 4'b0000);
        check("partial_rd_rdata", last_rdata, 32'hDE22BE44);
        txn(1'b1, 10'd6, 32'hCAFEF00D, 4'b1111);

        // Back-pressure: hold the read of 5 while a read of 6 waits.
        @(negedge clk);
        rr_mode = 2;
        rr_force = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 10'd5, 32'h0, 4'b0000);
        req_rw = 1'b0;
        req_addr = 10'd6;
        n_sent++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req_ready", DW'(req_ready), 0);
            check("stall_resp_rdata", resp_rdata, 32'hDE22BE44);
        end
        rr_force = 1'b1;
        @(negedge clk);
        check("release_req_ready", DW'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("queued_rd_valid", DW'(resp_valid), 1);
        check("queued_rd_rdata", resp_rdata, 32'hCAFEF00D);
        rr_mode = 0;
        wait_drain();

        // Out-of-range accesses, then confirm neighbours are intact.
        txn(1'b1, 10'd1000, 32'hFFFFFFFF, 4'b1111);
        check("oor_wr_err", DW'(last_err), 1);
        check("oor_wr_is_write", DW'(last_wr), 1);
        txn(1'b0, 10'd1023, 32'h0, 4'b0000);
        check("oor_rd_err", DW'(last_err), 1);
        check("oor_rd_rdata", last_rdata, 0);
        txn(1'b0, 10'd999, 32'h0, 4'b0000);
        txn(1'b0, 10'd0, 32'h0, 4'b0000);
        txn(1'b0, 10'd488, 32'h0, 4'b0000);

        // Mid-FULL asynchronous reset discards the pending response.
        @(negedge clk);
        rr_mode = 2;
        rr_force = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 10'd5, 32'h0, 4'b0000);
        req_valid = 1'b0;
        #2;
        check("prereset_resp_valid", DW'(resp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_resp_valid", DW'(resp_valid), 0);
        check("async_rst_resp_rdata", resp_rdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", DW'(req_ready), 1);
        rr_mode = 0;
        wait_drain();

        // Streaming write/read pairs at full throughput.
        c0 = cyc;
        w15 = '0;
        for (int i = 0; i < 16; i++) begin
            w15 = $urandom;
            send(1'b1, AW'(i), w15, '1);
            send(1'b0, AW'(i), '0, '0);
        end
        check("stream_cycles", DW'(cyc - c0), 32);
        req_valid = 1'b0;
        wait_drain();
        check("stream_last_rdata", last_rdata, w15);

        // Random traffic with random consumer stalls.
        rr_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = 1'b0;
                req_addr = AW'($urandom);
                @(posedge clk);
                #1;
            end else begin
                send(1'($urandom), AW'($urandom_range(0, 1023)), $urandom, SW'($urandom));
            end
        end
        req_valid = 1'b0;
        rr_mode = 0;
        wait_drain();
        check("accepted_count", DW'(n_accepted), DW'(n_sent));
        check("response_count", DW'(n_drained + n_discarded), DW'(n_accepted));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
